// File: rtl/div_result_buffer.sv
// div_result_buffer: captures the divider's single-cycle result pulse and its
// transaction ID in a small FIFO, then presents the head to writeback with a
// valid/ack handshake. Slots are reserved at issue time, and issue_allow_o
// holds the issue stage back so every result has somewhere to go.
// Optional feature macro: DIV_RESULT_BYPASS_EN. When it is defined, a result
// arriving at an empty buffer is shown on the writeback port in the same cycle.

package div_pkg;
  localparam int unsigned TRANS_ID_BITS = 4;
endpackage

module div_result_buffer #(
  parameter int unsigned DEPTH         = 2,
  parameter int unsigned TRANS_ID_BITS = div_pkg::TRANS_ID_BITS
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       div_start_i,
  input  logic                       div_valid_i,
  input  logic [63:0]                div_result_i,
  input  logic [TRANS_ID_BITS-1:0]   div_trans_id_i,
  output logic                       issue_allow_o,
  output logic                       wb_valid_o,
  output logic [63:0]                wb_result_o,
  output logic [TRANS_ID_BITS-1:0]   wb_trans_id_o,
  input  logic                       wb_ack_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  // One extra bit so occupancy plus reservations never wraps.
  localparam int unsigned OW = PW + 1;

  // IDLE: nothing in flight; WAIT: op in flight, keep its result;
  // DROP: op in flight, its result was flushed and must be discarded.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } op_state_e;

  op_state_e                state_r;
  logic [PW-1:0]            wr_ptr_r;
  logic [PW-1:0]            rd_ptr_r;
  logic [63:0]              res_mem_r [DEPTH];
  logic [TRANS_ID_BITS-1:0] id_mem_r  [DEPTH];
  logic                     overflow_r;

  logic          inflight_s;
  logic          drop_s;
  logic          inflight_next_s;
  logic [PW-1:0] count_s;
  logic          fifo_valid_s;
  logic          full_s;
  logic          bypass_s;
  logic          push_req_s;
  logic          push_s;
  logic          pop_s;
  logic          overflow_set_s;
  logic [OW-1:0] occupancy_s;
  logic [OW-1:0] limit_s;

  // Decode the reservation state into the in-flight and drop qualifiers.
  always_comb begin
    inflight_s = 1'b0;
    drop_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        inflight_s = 1'b0;
        drop_s     = 1'b0;
      end
      ST_WAIT: begin
        inflight_s = 1'b1;
        drop_s     = 1'b0;
      end
      ST_DROP: begin
        inflight_s = 1'b1;
        drop_s     = 1'b1;
      end
      default: begin
        inflight_s = 1'b0;
        drop_s     = 1'b0;
      end
    endcase
  end

  // FIFO occupancy, push/pop qualification and the optional bypass path.
  always_comb begin
    count_s      = wr_ptr_r - rd_ptr_r;
    fifo_valid_s = (count_s != {PW{1'b0}});
    full_s       = (count_s == PW'(DEPTH));
`ifdef DIV_RESULT_BYPASS_EN
    bypass_s     = !fifo_valid_s && div_valid_i && !drop_s && !flush_i;
`else
    bypass_s     = 1'b0;
`endif
    // A flush outranks any push arriving in the same cycle.
    push_req_s      = div_valid_i && !drop_s && !flush_i;
    pop_s           = fifo_valid_s && wb_ack_i;
    // A bypassed result consumed on the spot never touches storage; a full
    // FIFO still accepts a push when the head leaves in the same cycle.
    push_s          = push_req_s && !(bypass_s && wb_ack_i) && (!full_s || pop_s);
    overflow_set_s  = push_req_s && full_s && !pop_s;
    // A start and a result in the same cycle leave the reservation unchanged.
    inflight_next_s = (inflight_s && !div_valid_i) || div_start_i;
  end

  // Issue throttle: the start and ack terms are combinational so the throttle
  // closes in the cycle a start takes the last slot and reopens on a pop.
  always_comb begin
    occupancy_s   = OW'(count_s) + OW'(inflight_s) + OW'(div_start_i);
    limit_s       = OW'(DEPTH) + OW'(pop_s);
    issue_allow_o = (occupancy_s < limit_s);
  end

  // Writeback head: storage first, otherwise the bypass, otherwise zero.
  always_comb begin
    wb_valid_o    = fifo_valid_s || bypass_s;
    wb_result_o   = 64'd0;
    wb_trans_id_o = {TRANS_ID_BITS{1'b0}};
    if (fifo_valid_s) begin
      wb_result_o   = res_mem_r[rd_ptr_r[AW-1:0]];
      wb_trans_id_o = id_mem_r[rd_ptr_r[AW-1:0]];
    end else if (bypass_s) begin
      wb_result_o   = div_result_i;
      wb_trans_id_o = div_trans_id_i;
    end else begin
      wb_result_o   = 64'd0;
      wb_trans_id_o = {TRANS_ID_BITS{1'b0}};
    end
  end

  assign count_o    = count_s;
  assign overflow_o = overflow_r;

  // Read/write pointers; a flush empties the buffer outright.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else if (flush_i) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
    end
  end

  // Result and ID storage; the output mux masks unwritten slots.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      res_mem_r[wr_ptr_r[AW-1:0]] <= div_result_i;
      id_mem_r[wr_ptr_r[AW-1:0]]  <= div_trans_id_i;
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_r <= 1'b0;
    end else if (overflow_set_s) begin
      overflow_r <= 1'b1;
    end
  end

  // Reservation FSM for the divider's single outstanding operation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else if (flush_i) begin
      // Whatever is still in flight after this cycle belongs to the flushed
      // pipeline, so its result must be thrown away.
      state_r <= inflight_next_s ? ST_DROP : ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_r <= inflight_next_s ? ST_WAIT : ST_IDLE;
        ST_WAIT: state_r <= inflight_next_s ? ST_WAIT : ST_IDLE;
        ST_DROP: begin
          if (div_valid_i) begin
            state_r <= div_start_i ? ST_WAIT : ST_IDLE;
          end else begin
            state_r <= ST_DROP;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_result_buffer.sv
// Bench for div_result_buffer: directed scenarios followed by random divider
// traffic. A queue-based reference model is fed by the stimulus; a monitor
// compares every DUT output against it on each falling clock edge.

module tb_div_result_buffer;

  localparam int DEPTH = 2;
  localparam int IDW   = div_pkg::TRANS_ID_BITS;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           flush_i = 1'b0;
  logic           div_start_i = 1'b0;
  logic           div_valid_i = 1'b0;
  logic [63:0]    div_result_i = 64'd0;
  logic [IDW-1:0] div_trans_id_i = '0;
  logic           wb_ack_i = 1'b0;
  logic           issue_allow_o;
  logic           wb_valid_o;
  logic [63:0]    wb_result_o;
  logic [IDW-1:0] wb_trans_id_o;
  logic [CW-1:0]  count_o;
  logic           overflow_o;

  div_result_buffer #(.DEPTH(DEPTH), .TRANS_ID_BITS(IDW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .div_start_i    (div_start_i),
    .div_valid_i    (div_valid_i),
    .div_result_i   (div_result_i),
    .div_trans_id_i (div_trans_id_i),
    .issue_allow_o  (issue_allow_o),
    .wb_valid_o     (wb_valid_o),
    .wb_result_o    (wb_result_o),
    .wb_trans_id_o  (wb_trans_id_o),
    .wb_ack_i       (wb_ack_i),
    .count_o        (count_o),
    .overflow_o     (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [63:0]    res;
    logic [IDW-1:0] id;
  } entry_t;

  // Reference model state: buffered results, in-flight op, discard pending.
  entry_t exp_q[$];
  logic   m_inflight = 1'b0;
  logic   m_drop     = 1'b0;
  logic   m_ovf      = 1'b0;
  bit     pop_seen   = 1'b0;
  bit     byp_taken  = 1'b0;
  int     n_checks   = 0;
  int     n_pass     = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: applies one cycle of stimulus at each rising edge.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_q.delete();
      m_inflight <= 1'b0;
      m_drop     <= 1'b0;
      m_ovf      <= 1'b0;
    end else if (flush_i) begin
      exp_q.delete();
      m_inflight <= (m_inflight && !div_valid_i) || div_start_i;
      m_drop     <= (m_inflight && !div_valid_i) || div_start_i;
    end else begin
      if (pop_seen) begin
        void'(exp_q.pop_front());
      end
      if (div_valid_i && !m_drop && !byp_taken) begin
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back({div_result_i, div_trans_id_i});
        end else begin
          m_ovf <= 1'b1;
        end
      end
      m_inflight <= (m_inflight && !div_valid_i) || div_start_i;
      m_drop     <= m_drop && !div_valid_i;
    end
  end

  // Monitor: compares DUT outputs with the model away from the rising edge.
  initial begin
    entry_t head;
    logic   ev;
    logic   byp;
    int     occ;
    @(posedge clk_i);
    forever begin
      @(negedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        #1;
        chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_overflow", 64'(overflow_o), 64'd0);
        chk("rst_wb_result", wb_result_o, 64'd0);
        chk("rst_wb_id", 64'(wb_trans_id_o), 64'd0);
        chk("rst_issue_allow", 64'(issue_allow_o), 64'd1);
        pop_seen  = 1'b0;
        byp_taken = 1'b0;
      end else begin
        ev   = 1'b0;
        byp  = 1'b0;
        head = '0;
        if (exp_q.size() > 0) begin
          ev   = 1'b1;
          head = exp_q[0];
        end
`ifdef DIV_RESULT_BYPASS_EN
        else if (div_valid_i && !m_drop && !flush_i) begin
          ev   = 1'b1;
          byp  = 1'b1;
          head = {div_result_i, div_trans_id_i};
        end
`endif
        chk("wb_valid", 64'(wb_valid_o), 64'(ev));
        if (ev) begin
          chk("wb_result", wb_result_o, head.res);
          chk("wb_trans_id", 64'(wb_trans_id_o), 64'(head.id));
        end
        chk("count", 64'(count_o), 64'(exp_q.size()));
        occ = exp_q.size() + int'(m_inflight) + int'(div_start_i);
        if (exp_q.size() > 0 && wb_ack_i) begin
          occ = occ - 1;
        end
        chk("issue_allow", 64'(issue_allow_o), 64'(occ < DEPTH));
        chk("overflow", 64'(overflow_o), 64'(m_ovf));
        pop_seen  = ev && !byp && wb_ack_i;
        byp_taken = byp && wb_ack_i;
      end
    end
  end

  task automatic drive(input logic st, input logic v, input logic [63:0] r,
                       input logic [IDW-1:0] id, input logic ack, input logic fl);
    @(posedge clk_i);
    #1;
    div_start_i    = st;
    div_valid_i    = v;
    div_result_i   = r;
    div_trans_id_i = id;
    wb_ack_i       = ack;
    flush_i        = fl;
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 64'd0, '0, ack, 1'b0);
    end
  endtask

  // Reset asserted between clock edges, held for two edges.
  task automatic do_reset();
    drive(1'b0, 1'b0, 64'd0, '0, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    bit busy;
    int cnt;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Single op, writeback always ready.
    drive(1'b1, 1'b0, 64'd0, '0, 1'b1, 1'b0);
    idle(9, 1'b1);
    drive(1'b0, 1'b1, 64'h0000_0000_0000_0007, IDW'(3), 1'b1, 1'b0);
    idle(3, 1'b1);

    // Backpressure fill, then drain one at a time.
    drive(1'b1, 1'b0, 64'd0, '0, 1'b0, 1'b0);
    idle(3, 1'b0);
    drive(1'b0, 1'b1, 64'h1111, IDW'(1), 1'b0, 1'b0);
    drive(1'b1, 1'b0, 64'd0, '0, 1'b0, 1'b0);
    idle(3, 1'b0);
    drive(1'b0, 1'b1, 64'h2222, IDW'(2), 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(1, 1'b0);
    idle(2, 1'b1);

    // Full FIFO with a push and a pop in the same cycle.
    drive(1'b0, 1'b1, 64'hA1, IDW'(1), 1'b0, 1'b0);
    drive(1'b0, 1'b1, 64'hA2, IDW'(2), 1'b0, 1'b0);
    drive(1'b0, 1'b1, 64'hA6, IDW'(6), 1'b1, 1'b0);
    idle(1, 1'b0);
    idle(3, 1'b1);

    // Flush while an op is in flight; its result must vanish.
    drive(1'b1, 1'b0, 64'd0, '0, 1'b1, 1'b0);
    idle(1, 1'b1);
    drive(1'b0, 1'b0, 64'd0, '0, 1'b1, 1'b1);
    idle(1, 1'b1);
    drive(1'b0, 1'b1, 64'hDEAD, IDW'(5), 1'b1, 1'b0);
    idle(2, 1'b1);
    drive(1'b1, 1'b0, 64'd0, '0, 1'b1, 1'b0);
    idle(3, 1'b1);
    drive(1'b0, 1'b1, 64'h1234, IDW'(6), 1'b1, 1'b0);
    idle(2, 1'b1);

    // Forced overflow: three results, no starts, no acks.
    drive(1'b0, 1'b1, 64'hB0, IDW'(10), 1'b0, 1'b0);
    drive(1'b0, 1'b1, 64'hB1, IDW'(11), 1'b0, 1'b0);
    drive(1'b0, 1'b1, 64'hB2, IDW'(12), 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(4, 1'b1);
    do_reset();
    idle(2, 1'b1);

    // Asynchronous reset with one entry buffered.
    drive(1'b0, 1'b1, 64'hC0FFEE, IDW'(9), 1'b0, 1'b0);
    idle(2, 1'b0);
    do_reset();
    idle(2, 1'b1);

    // Random traffic from a single-outstanding divider model.
    busy = 1'b0;
    cnt  = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk_i);
      #1;
      div_start_i  = 1'b0;
      div_valid_i  = 1'b0;
      div_result_i = 64'd0;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          div_valid_i    = 1'b1;
          div_result_i   = {$urandom, $urandom};
          div_trans_id_i = IDW'($urandom);
          busy           = 1'b0;
        end
      end
      wb_ack_i = ($urandom_range(0, 3) != 0);
      flush_i  = ($urandom_range(0, 49) == 0);
      #1;
      if (!busy && issue_allow_o && ($urandom_range(0, 1) == 1)) begin
        div_start_i = 1'b1;
        busy        = 1'b1;
        cnt         = $urandom_range(1, 6);
      end
    end
    idle(10, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_result_buffer.md
# div_result_buffer

Result buffer directly downstream of the radix-2 divider `div_two`. It captures the one-cycle result pulse from the divider, together with its transaction ID, into a small FIFO, so results are never lost. It then presents them to the writeback port with a valid/ack handshake. Slots are reserved when a division is accepted, and `issue_allow_o` throttles the issue stage, so the divider never produces a result with nowhere to put it.

## Interface
Parameters:
- `DEPTH`, default 2: FIFO entries. Power of two, at least 2.
- `TRANS_ID_BITS`, default from `div_pkg`: transaction ID width.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `flush_i`  in  1  pipeline flush: drops all buffered and in-flight results.
- `div_start_i`  in  1  divider accepted a request this cycle (divider `div_valid_i & div_ready_o`).
- `div_valid_i`  in  1  divider result pulse (divider `div_valid_o`).
- `div_result_i`  in  64  divider `result_o`.
- `div_trans_id_i`  in  TRANS_ID_BITS  divider `div_trans_id_o`.
- `issue_allow_o`  out  1  issue stage may start a new division.
- `wb_valid_o`  out  1  head entry valid.
- `wb_result_o`  out  64  head result.
- `wb_trans_id_o`  out  TRANS_ID_BITS  head transaction ID.
- `wb_ack_i`  in  1  writeback consumed the head this cycle.
- `count_o`  out  $clog2(DEPTH)+1  occupied entries.
- `overflow_o`  out  1  sticky error flag: push attempted with FIFO full.

## Operation
- Storage: circular FIFO with `wr_ptr` and `rd_ptr`, each $clog2(DEPTH)+1 bits wide. The MSB distinguishes full from empty. Pointers wrap modulo 2·DEPTH.
- Reservation counter `inflight` (0..1) tracks the divider's single outstanding operation:
  - +1 on `div_start_i`.
  - −1 on an accepted `div_valid_i`.
  - Both in the same cycle: stays at its current value.
- `issue_allow_o = (count + inflight) < DEPTH`. It must fall in the same cycle as `div_start_i` if that start fills the last slot; this is a combinational term on `div_start_i`.
- Push happens when `div_valid_i && !drop_q`. Result and ID are written at `wr_ptr`.
- Pop happens when `wb_valid_o && wb_ack_i`. `wb_ack_i` without `wb_valid_o` is ignored.
- Push and pop in the same cycle: both occur and `count` is unchanged. This is legal when full, because the pop frees the slot.
- Push with `count == DEPTH` and no pop in that cycle: the data is dropped and `overflow_o` is set. The flag stays set until reset.
- Flush:
  - Clears both pointers, so `count = 0`.
  - If `inflight == 1` or `div_start_i` is high, sets `drop_q`. The next `div_valid_i` is then discarded and clears `drop_q` and `inflight`.
  - Flush takes priority over a push or pop in the same cycle.
- States, derived from `drop_q` and `inflight`:
  - IDLE (no op in flight).
  - WAIT (op in flight, result will be kept).
  - DROP (op in flight, result will be discarded).
- Transitions:
  - IDLE→WAIT on start.
  - WAIT→IDLE on result.
  - WAIT→DROP on flush.
  - DROP→IDLE on result.
  - IDLE→DROP on start together with flush.

## Timing
- Reset values: `wb_valid_o=0`, `wb_result_o=0`, `wb_trans_id_o=0`, `count_o=0`, `overflow_o=0`, `issue_allow_o=1`. Pointers 0, `inflight=0`, `drop_q=0`.
- Base latency: `div_valid_i` in cycle N gives `wb_valid_o` in cycle N+1 with that data.
- Outputs are held stable until acknowledged.
- Ordering is FIFO, which matches the divider's in-order completion.
- Throughput: one push and one pop per cycle.
- Reset asserted mid-operation: all state clears asynchronously. Any result arriving after reset with `inflight=0` is still pushed.

## Configuration
- `DIV_RESULT_BYPASS_EN` defined:
  - When the FIFO is empty and `div_valid_i && !drop_q`, `wb_valid_o`, `wb_result_o` and `wb_trans_id_o` are driven combinationally from the divider inputs in cycle N (zero latency).
  - If `wb_ack_i` is high in that cycle, the entry is not written.
  - If `wb_ack_i` is low, it is written as normal.
- `DIV_RESULT_BYPASS_EN` not defined: outputs come only from FIFO storage, with one-cycle latency.

## Test plan
- Reset, then a single op: `div_start_i` pulse, then 10 cycles later `div_valid_i` with result `0x0000_0000_0000_0007` and ID 3, with `wb_ack_i` held high. Required: `wb_valid_o` high for exactly 1 cycle at N+1 (N with bypass), carrying 7 and ID 3. `count_o` returns to 0.
- Backpressure fill, DEPTH=2, `wb_ack_i=0`:
  - After two completed ops, `count_o=2` and `issue_allow_o=0`.
  - After one `wb_ack_i`, `issue_allow_o=1` the same cycle.
  - Pop order gives IDs 1 then 2.
- Simultaneous events with FIFO full: push and pop in the same cycle. Required: `count_o` stays at 2, `overflow_o` stays 0, and the new entry appears after the old one.
- Flush during flight: start, flush two cycles later, then a result 0xDEAD with ID 5. Required: 0xDEAD is never shown on `wb_result_o`, `count_o=0`, `issue_allow_o=1` after the result arrives, and the next op is delivered normally.
- Forced overflow: inject `div_valid_i` three times with no starts and no acks. Required: the first two entries are stored, the third is dropped, and `overflow_o=1` persists until `rst_ni` is asserted.
- Asynchronous reset asserted mid-clock with 1 entry buffered. Required: `wb_valid_o` and `count_o` go to 0 immediately, without waiting for a clock edge.
